// File: rtl/down_timer.sv
// Presettable down-counter with reload register and IDLE/RUN/DONE run control.
// Stages cascade through BI/BO; BO is combinational so a whole chain decrements on one edge.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             EN,
  input  logic             BI,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TC,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [WIDTH-1:0] r_r, r_nxt;
  logic             tc_r, tc_nxt;
  logic             step;
  logic             zero;

  assign step = (state == RUN) && EN && BI;
  assign zero = (q_r == '0);

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      state <= IDLE;
      q_r   <= '0;
      r_r   <= '0;
      tc_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      q_r   <= q_nxt;
      r_r   <= r_nxt;
      tc_r  <= tc_nxt;
    end
  end

  // LOAD overrides everything; otherwise START/step act according to state.
  // The terminal step replaces the wrap from 0, so Q never underflows.
  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    r_nxt     = r_r;
    tc_nxt    = 1'b0;
    if (!LOAD) begin
      r_nxt     = D;
      q_nxt     = D;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (START) state_nxt = RUN;
        end
        DONE: begin
          if (START) begin
            q_nxt     = r_r;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (step) begin
            if (zero) begin
              tc_nxt = 1'b1;
              if (MODE) q_nxt = r_r;
              else      state_nxt = DONE;
            end else begin
              q_nxt = q_r - 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign Q    = q_r;
  assign TC   = tc_r;
  assign BUSY = (state == RUN);
  assign BO   = step && zero;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: a single stage plus a two-stage cascade,
// driven by directed sequences and random stimulus against a reference model.
module tb_down_timer;

  logic       CLK = 1'b0;
  logic       MR, LOAD, START, EN, BI, MODE;
  logic [3:0] D;
  logic [7:0] DC;
  logic [3:0] Q, ql, qh;
  logic       BO, TC, BUSY;
  logic       bol, boh, tcl, tch, busyl, busyh;

  always #5 CLK = ~CLK;

  down_timer #(.WIDTH(4)) dut (
    .CLK(CLK), .MR(MR), .LOAD(LOAD), .D(D), .START(START), .EN(EN), .BI(BI),
    .MODE(MODE), .Q(Q), .BO(BO), .TC(TC), .BUSY(BUSY)
  );

  down_timer #(.WIDTH(4)) lo (
    .CLK(CLK), .MR(MR), .LOAD(LOAD), .D(DC[3:0]), .START(START), .EN(EN), .BI(1'b1),
    .MODE(MODE), .Q(ql), .BO(bol), .TC(tcl), .BUSY(busyl)
  );

  down_timer #(.WIDTH(4)) hi (
    .CLK(CLK), .MR(MR), .LOAD(LOAD), .D(DC[7:4]), .START(START), .EN(EN), .BI(bol),
    .MODE(MODE), .Q(qh), .BO(boh), .TC(tch), .BUSY(busyh)
  );

  // Model phase: 0 = stopped, 1 = counting, 2 = finished one-shot
  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    int         phase;
    logic       tc;
  } mstate_t;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic [7:0] qc;
    logic       tch;
  } exp_t;

  exp_t    sb[$];
  mstate_t m, ml, mh;
  int      compared   = 0;
  int      mismatched = 0;

  function automatic mstate_t mzero();
    mstate_t z;
    z.q = '0; z.r = '0; z.phase = 0; z.tc = 1'b0;
    return z;
  endfunction

  function automatic mstate_t mstep(mstate_t s, logic mr, logic ld_n, logic start,
                                    logic en, logic bi, logic mode, logic [3:0] d);
    mstate_t n;
    n    = s;
    n.tc = 1'b0;
    if (!mr) n = mzero();
    else if (!ld_n) begin
      n.r = d; n.q = d; n.phase = 0;
    end else if (s.phase == 0) begin
      if (start) n.phase = 1;
    end else if (s.phase == 2) begin
      if (start) begin n.q = s.r; n.phase = 1; end
    end else if (en && bi) begin
      if (s.q == 4'd0) begin
        n.tc = 1'b1;
        if (mode) n.q = s.r;
        else      n.phase = 2;
      end else n.q = s.q - 4'd1;
    end
    return n;
  endfunction

  function automatic logic mbo(mstate_t s, logic en, logic bi);
    return (s.phase == 1) && en && bi && (s.q == 4'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    logic bol_e;
    exp_t e;
    #1;
    if (!MR) begin
      m = mzero(); ml = mzero(); mh = mzero();
    end
    chk("bo", 32'(BO), 32'(mbo(m, EN, BI)));
    bol_e = mbo(ml, EN, 1'b1);
    chk("bo_lo", 32'(bol), 32'(bol_e));
    m  = mstep(m,  MR, LOAD, START, EN, BI,    MODE, D);
    ml = mstep(ml, MR, LOAD, START, EN, 1'b1,  MODE, DC[3:0]);
    mh = mstep(mh, MR, LOAD, START, EN, bol_e, MODE, DC[7:4]);
    e.q    = m.q;
    e.tc   = m.tc;
    e.busy = (m.phase == 1);
    e.qc   = {mh.q, ml.q};
    e.tch  = mh.tc;
    sb.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q",       32'(Q),        32'(e.q));
      chk("tc",      32'(TC),       32'(e.tc));
      chk("busy",    32'(BUSY),     32'(e.busy));
      chk("cas_q",   32'({qh, ql}), 32'(e.qc));
      chk("cas_tch", 32'(tch),      32'(e.tch));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    MR = 1'b0; LOAD = 1'b1; START = 1'b0; EN = 1'b1; BI = 1'b1; MODE = 1'b0;
    D = '0; DC = '0;
    m = mzero(); ml = mzero(); mh = mzero();
    @(negedge CLK);
    chk("rst_q",    32'(Q),    32'd0);
    chk("rst_tc",   32'(TC),   32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    repeat (2) tick();
    MR = 1'b1;
    tick();

    // One-shot from 3, then restart from DONE
    D = 4'd3; LOAD = 1'b0; tick();
    LOAD = 1'b1; MODE = 1'b0; START = 1'b1; tick();
    START = 1'b0; repeat (6) tick();
    START = 1'b1; tick();
    START = 1'b0; repeat (6) tick();

    // Periodic from 2
    D = 4'd2; LOAD = 1'b0; tick();
    LOAD = 1'b1; MODE = 1'b1; START = 1'b1; tick();
    START = 1'b0; repeat (9) tick();

    // Enable gating
    for (int i = 0; i < 8; i++) begin
      EN = (i % 2 == 0);
      tick();
    end
    EN = 1'b1;

    // Asynchronous reset mid-run with Q=5
    D = 4'd5; LOAD = 1'b0; MODE = 1'b0; tick();
    LOAD = 1'b1; START = 1'b1; tick();
    START = 1'b0; EN = 1'b0; tick();
    #2;
    MR = 1'b0;
    #1;
    chk("amr_q",    32'(Q),    32'd0);
    chk("amr_busy", 32'(BUSY), 32'd0);
    chk("amr_tc",   32'(TC),   32'd0);
    chk("amr_bo",   32'(BO),   32'd0);
    @(negedge CLK);
    EN = 1'b1;
    tick();
    MR = 1'b1;
    tick();

    // LOAD against a terminal step, then against START
    D = 4'd1; LOAD = 1'b0; tick();
    LOAD = 1'b1; START = 1'b1; tick();
    START = 1'b0; tick();
    D = 4'd7; LOAD = 1'b0; tick();
    START = 1'b1; tick();
    LOAD = 1'b1; START = 1'b0; tick();

    // Cascade: one-shot from 0x10, periodic from 0x23
    DC = 8'h10; LOAD = 1'b0; tick();
    LOAD = 1'b1; MODE = 1'b0; START = 1'b1; tick();
    START = 1'b0; repeat (5) tick();
    DC = 8'h23; LOAD = 1'b0; tick();
    LOAD = 1'b1; MODE = 1'b1; START = 1'b1; tick();
    START = 1'b0; repeat (40) tick();

    // Random
    repeat (3000) begin
      MR    = ($urandom_range(0, 99) != 0);
      LOAD  = ($urandom_range(0, 9) != 0);
      START = ($urandom_range(0, 3) == 0);
      EN    = ($urandom_range(0, 3) != 0);
      BI    = ($urandom_range(0, 7) != 0);
      MODE  = 1'($urandom);
      D     = 4'($urandom);
      DC    = 8'($urandom);
      tick();
    end

    @(posedge CLK);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
